// File: rtl/tpg_axi_pkg.sv
// tpg_axi_pkg: shared AXI4-Lite types for the TPG slave memory.
// Response encoding, byte-lane constants and channel FSM states.
package tpg_axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  localparam int TPG_AXI_BYTE_W = 8;
  localparam int TPG_AXI_STRB_W = 4;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HOLD,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/tpg_axil_slave_ram.sv
// tpg_axil_slave_ram: simple dual-port word RAM, byte-enabled write
// port, registered read port. Ports: clk, rst_n, wr_*, rd_*.
module tpg_axil_slave_ram
  import tpg_axi_pkg::*;
#(
  parameter int STRB_W = TPG_AXI_STRB_W,
  parameter int DEPTH  = 256,
  localparam int DATA_W = STRB_W * TPG_AXI_BYTE_W,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset: data survives ARESETN.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*TPG_AXI_BYTE_W +: TPG_AXI_BYTE_W]
            <= wr_data[b*TPG_AXI_BYTE_W +: TPG_AXI_BYTE_W];
        end
      end
    end
  end

  // Reading the array with non-blocking update gives
  // read-before-write on a same-edge collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/tpg_axil_slave_mem.sv
// tpg_axil_slave_mem: AXI4-Lite memory slave, single-beat R/W with strobes.
// Ports: ACLK, ARESETN, S_AXI_AW*/W*/B*/AR*/R*. Option: TPG_SLV_ADDR_ERR_EN.
module tpg_axil_slave_mem
  import tpg_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH          = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int SW    = DW / TPG_AXI_BYTE_W;
  localparam int OFF_W = $clog2(SW);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int TOP_B = OFF_W + IDX_W;

  typedef logic [IDX_W-1:0] idx_t;

  wr_state_t w_state;
  wr_state_t w_state_nxt;
  rd_state_t r_state;
  rd_state_t r_state_nxt;

  logic      run_q;
  logic      aw_full;
  logic      aw_err;
  idx_t      aw_idx;
  logic      w_full;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  axi_resp_t b_resp;
  axi_resp_t r_resp;
  logic      r_err;

  logic      aw_hs;
  logic      w_hs;
  logic      ar_hs;
  logic      commit;
  logic      aw_oor;
  logic      ar_oor;
  idx_t      aw_idx_in;
  idx_t      ar_idx_in;
  logic [DW-1:0] ram_q;
  logic      unused_addr;

  // Sub-word bits never take part in decode: alignment is forced.
  assign aw_idx_in = S_AXI_AWADDR[OFF_W +: IDX_W];
  assign ar_idx_in = S_AXI_ARADDR[OFF_W +: IDX_W];

`ifdef TPG_SLV_ADDR_ERR_EN
  assign aw_oor = |S_AXI_AWADDR[AW-1:TOP_B];
  assign ar_oor = |S_AXI_ARADDR[AW-1:TOP_B];
  assign unused_addr = ^{S_AXI_AWADDR[OFF_W-1:0],
                         S_AXI_ARADDR[OFF_W-1:0]};
`else
  // Upper bits dropped: addresses wrap modulo the RAM size.
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
  assign unused_addr = ^{S_AXI_AWADDR[AW-1:TOP_B],
                         S_AXI_AWADDR[OFF_W-1:0],
                         S_AXI_ARADDR[AW-1:TOP_B],
                         S_AXI_ARADDR[OFF_W-1:0]};
`endif

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = (w_state == W_HOLD) && aw_full && w_full;

  // State registers. run_q keeps every READY low while in reset
  // and for the first edge after release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      run_q   <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      run_q   <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE: if (aw_hs || w_hs) w_state_nxt = W_HOLD;
      W_HOLD: if (commit) w_state_nxt = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_state_nxt = R_RESP;
      R_RESP: if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Channel outputs, decoded from registers only.
  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    if (run_q) begin
      S_AXI_AWREADY = (w_state != W_RESP) && !aw_full;
      S_AXI_WREADY  = (w_state != W_RESP) && !w_full;
      S_AXI_BVALID  = (w_state == W_RESP);
      S_AXI_ARREADY = (r_state == R_IDLE);
      S_AXI_RVALID  = (r_state == R_RESP);
    end
  end

  // Write holders: AW and W land independently, cleared on commit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
      aw_err  <= 1'b0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      b_resp  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= aw_idx_in;
        aw_err  <= aw_oor;
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end else if (commit) begin
        w_full <= 1'b0;
      end
      if (commit) begin
        b_resp <= aw_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Read response side-band; data itself is the RAM read register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_resp <= RESP_OKAY;
      r_err  <= 1'b0;
    end else if (ar_hs) begin
      r_resp <= ar_oor ? RESP_SLVERR : RESP_OKAY;
      r_err  <= ar_oor;
    end
  end

  tpg_axil_slave_ram #(
    .STRB_W (SW),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (commit && !aw_err),
    .wr_idx  (aw_idx),
    .wr_data (w_data),
    .wr_strb (w_strb),
    .rd_en   (ar_hs),
    .rd_idx  (ar_idx_in),
    .rd_data (ram_q)
  );

  assign S_AXI_BRESP = b_resp;
  assign S_AXI_RRESP = r_resp;
  assign S_AXI_RDATA = r_err ? '0 : ram_q;

endmodule

// File: tb/tb_tpg_axil_slave_mem.sv
// tb_tpg_axil_slave_mem: scoreboard bench for the AXI4-Lite slave memory.
// Directed scenarios plus randomized traffic against a word-array model.
module tb_tpg_axil_slave_mem;
  import tpg_axi_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rexp_t;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AW-1:0] S_AXI_AWADDR = '0;
  logic          S_AXI_AWVALID = 1'b0;
  logic          S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic          S_AXI_WVALID = 1'b0;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [AW-1:0] S_AXI_ARADDR = '0;
  logic          S_AXI_ARVALID = 1'b0;
  logic          S_AXI_ARREADY;
  logic [DW-1:0] S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;

  int checks = 0;
  int failures = 0;
  int b_done = 0;
  int r_done = 0;
  int bp_mode = 0;

  logic [DW-1:0] model [DEPTH];
  logic [1:0]    bq [$];
  rexp_t         rq [$];

  tpg_axil_slave_mem #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .MEM_DEPTH          (DEPTH)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  function automatic void chk(input string n,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endfunction

  function automatic void timeout(input string n);
    checks++;
    failures++;
    $display("FAIL %s timed out waiting for DUT", n);
  endfunction

  // Reference model: a plain word array, strobes merge bytes.
  function automatic logic [1:0] model_write(input logic [AW-1:0] a,
                                             input logic [DW-1:0] d,
                                             input logic [3:0] s);
    int idx;
`ifdef TPG_SLV_ADDR_ERR_EN
    if (a >= 32'(DEPTH * 4)) return RESP_SLVERR;
`endif
    idx = int'((a >> 2) % DEPTH);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    end
    return RESP_OKAY;
  endfunction

  function automatic rexp_t model_read(input logic [AW-1:0] a);
    rexp_t e;
    e.resp = RESP_OKAY;
    e.data = model[int'((a >> 2) % DEPTH)];
`ifdef TPG_SLV_ADDR_ERR_EN
    if (a >= 32'(DEPTH * 4)) begin
      e.resp = RESP_SLVERR;
      e.data = '0;
    end
`endif
    return e;
  endfunction

  // Ready generator: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      if (bp_mode == 1) begin
        S_AXI_BREADY = 1'($urandom_range(0, 1));
        S_AXI_RREADY = 1'($urandom_range(0, 1));
      end else begin
        S_AXI_BREADY = (bp_mode == 0);
        S_AXI_RREADY = (bp_mode == 0);
      end
    end
  end

  // Monitor: pops the scoreboard on each completed response.
  initial begin
    rexp_t e;
    logic [1:0] eb;
    forever begin
      @(negedge ACLK);
      if (ARESETN && S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected bresp=%b", S_AXI_BRESP);
        end else begin
          eb = bq.pop_front();
          chk("bresp", 64'(S_AXI_BRESP), 64'(eb));
        end
        b_done++;
      end
      if (ARESETN && S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL r_unexpected rdata=%h", S_AXI_RDATA);
        end else begin
          e = rq.pop_front();
          chk("rdata", 64'(S_AXI_RDATA), 64'(e.data));
          chk("rresp", 64'(S_AXI_RRESP), 64'(e.resp));
        end
        r_done++;
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_aw(input logic [AW-1:0] a, input int dly);
    int n = 0;
    repeat (dly) step();
    S_AXI_AWADDR  = a;
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    while (!S_AXI_AWREADY && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!S_AXI_AWREADY) timeout("aw_handshake");
    step();
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic drive_w(input logic [DW-1:0] d,
                         input logic [3:0] s, input int dly);
    int n = 0;
    repeat (dly) step();
    S_AXI_WDATA  = d;
    S_AXI_WSTRB  = s;
    S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    while (!S_AXI_WREADY && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!S_AXI_WREADY) timeout("w_handshake");
    step();
    S_AXI_WVALID = 1'b0;
  endtask

  task automatic drive_ar(input logic [AW-1:0] a);
    int n = 0;
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    while (!S_AXI_ARREADY && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!S_AXI_ARREADY) timeout("ar_handshake");
    step();
    S_AXI_ARVALID = 1'b0;
  endtask

  task automatic wait_b(input int tgt);
    int n = 0;
    while (b_done < tgt && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (b_done < tgt) timeout("b_response");
    step();
  endtask

  task automatic wait_r(input int tgt);
    int n = 0;
    while (r_done < tgt && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (r_done < tgt) timeout("r_response");
    step();
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, input int daw, input int dw);
    int tgt = b_done + 1;
    bq.push_back(model_write(a, d, s));
    fork
      drive_aw(a, daw);
      drive_w(d, s, dw);
    join
    wait_b(tgt);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input bit lat);
    int tgt = r_done + 1;
    rq.push_back(model_read(a));
    drive_ar(a);
    if (lat) chk("r_latency", 64'(S_AXI_RVALID), 64'd1);
    wait_r(tgt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tb;
    int tr;
    int n;
    rexp_t e;
    logic [AW-1:0] a;

    // Reset state.
    #22;
    chk("rst_awready", 64'(S_AXI_AWREADY), 64'd0);
    chk("rst_wready",  64'(S_AXI_WREADY),  64'd0);
    chk("rst_arready", 64'(S_AXI_ARREADY), 64'd0);
    chk("rst_bvalid",  64'(S_AXI_BVALID),  64'd0);
    chk("rst_rvalid",  64'(S_AXI_RVALID),  64'd0);
    chk("rst_bresp",   64'(S_AXI_BRESP),   64'd0);
    chk("rst_rresp",   64'(S_AXI_RRESP),   64'd0);
    chk("rst_rdata",   64'(S_AXI_RDATA),   64'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    step();
    step();

    // Known contents everywhere.
    for (int i = 0; i < DEPTH; i++) begin
      axi_write(32'(i * 4), $urandom, 4'hF, 0, 0);
    end

    // T1: same-cycle AW/W, B two cycles later, 1-cycle read.
    tb = b_done + 1;
    bq.push_back(model_write(32'h10, 32'hDEADBEEF, 4'hF));
    S_AXI_AWADDR  = 32'h10;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA   = 32'hDEADBEEF;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_WVALID  = 1'b1;
    @(negedge ACLK);
    chk("t1_awready", 64'(S_AXI_AWREADY), 64'd1);
    chk("t1_wready",  64'(S_AXI_WREADY),  64'd1);
    step();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    @(negedge ACLK);
    chk("t1_bvalid_c1", 64'(S_AXI_BVALID), 64'd0);
    @(negedge ACLK);
    chk("t1_bvalid_c2", 64'(S_AXI_BVALID), 64'd1);
    chk("t1_bresp_c2",  64'(S_AXI_BRESP),  64'd0);
    wait_b(tb);
    axi_read(32'h10, 1'b1);

    // T2: W ahead of AW by 3 cycles, partial strobes.
    axi_write(32'h20, 32'hAAAAAAAA, 4'hF, 0, 0);
    axi_write(32'h20, 32'h11223344, 4'b0101, 3, 0);
    rq.push_back('{data: 32'hAA22AA44, resp: RESP_OKAY});
    tr = r_done + 1;
    drive_ar(32'h20);
    wait_r(tr);

    // WSTRB=0: still answered, word untouched.
    axi_write(32'h24, 32'hFFFFFFFF, 4'h0, 1, 2);
    axi_read(32'h24, 1'b0);

    // T3: backpressure on both response channels.
    bp_mode = 2;
    step();
    step();
    tb = b_done + 1;
    tr = r_done + 1;
    bq.push_back(model_write(32'h50, 32'h0BADF00D, 4'hF));
    e = model_read(32'h60);
    rq.push_back(e);
    fork
      drive_aw(32'h50, 0);
      drive_w(32'h0BADF00D, 4'hF, 0);
      drive_ar(32'h60);
    join
    n = 0;
    while (!(S_AXI_BVALID && S_AXI_RVALID) && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!(S_AXI_BVALID && S_AXI_RVALID)) timeout("t3_valids");
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk("t3_bvalid",  64'(S_AXI_BVALID),  64'd1);
      chk("t3_bresp",   64'(S_AXI_BRESP),   64'd0);
      chk("t3_rvalid",  64'(S_AXI_RVALID),  64'd1);
      chk("t3_rdata",   64'(S_AXI_RDATA),   64'(e.data));
      chk("t3_awready", 64'(S_AXI_AWREADY), 64'd0);
      chk("t3_wready",  64'(S_AXI_WREADY),  64'd0);
      chk("t3_arready", 64'(S_AXI_ARREADY), 64'd0);
    end
    bp_mode = 0;
    wait_b(tb);
    wait_r(tr);

    // T4: write commit and AR on the same edge -> old data.
    axi_write(32'h30, 32'h1, 4'hF, 0, 0);
    tb = b_done + 1;
    tr = r_done + 1;
    rq.push_back(model_read(32'h30));
    bq.push_back(model_write(32'h30, 32'h2, 4'hF));
    drive_w(32'h2, 4'hF, 0);
    S_AXI_AWADDR  = 32'h30;
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    chk("t4_awready", 64'(S_AXI_AWREADY), 64'd1);
    step();
    S_AXI_AWVALID = 1'b0;
    S_AXI_ARADDR  = 32'h30;
    S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    chk("t4_arready", 64'(S_AXI_ARREADY), 64'd1);
    step();
    S_AXI_ARVALID = 1'b0;
    wait_b(tb);
    wait_r(tr);
    axi_read(32'h30, 1'b0);

    // T5: one word past the end of the RAM.
    axi_write(32'h0, 32'h13572468, 4'hF, 0, 0);
    axi_write(32'(DEPTH * 4), 32'h55AA55AA, 4'hF, 0, 0);
    axi_read(32'h0, 1'b0);
    axi_read(32'(DEPTH * 4 + 8), 1'b0);

    // Randomized traffic with random ready and AW/W skew.
    bp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH * 4 - 1));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        axi_read(a, 1'b0);
      end
    end
    bp_mode = 0;
    step();
    step();

    // T6: reset while BVALID is pending.
    bp_mode = 2;
    step();
    step();
    bq.push_back(model_write(32'h40, 32'hCAFEF00D, 4'hF));
    fork
      drive_aw(32'h40, 0);
      drive_w(32'hCAFEF00D, 4'hF, 0);
    join
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("t6_bvalid_pre", 64'(S_AXI_BVALID), 64'd1);
    #1;
    ARESETN = 1'b0;
    #1;
    chk("t6_bvalid_async", 64'(S_AXI_BVALID), 64'd0);
    chk("t6_bresp_async",  64'(S_AXI_BRESP),  64'd0);
    bq.delete();
    repeat (3) @(posedge ACLK);
    #1;
    chk("t6_awready_rst", 64'(S_AXI_AWREADY), 64'd0);
    chk("t6_arready_rst", 64'(S_AXI_ARREADY), 64'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    bp_mode = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      chk("t6_no_stale_b", 64'(S_AXI_BVALID), 64'd0);
    end
    step();
    axi_read(32'h40, 1'b0);
    axi_read(32'h10, 1'b0);

    repeat (4) step();
    chk("bq_drained", 64'(bq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
